// File: rtl/max_select.sv
// Streaming max-value selector: tracks the largest word of a search and the
// address of its first occurrence, reporting both with a level done.
module max_select #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int SIGNED = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_last,
   output logic [DATA_W-1:0] max_val,
   output logic [ADDR_W-1:0] max_addr,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0] state;
   logic       first;
   logic       greater;

   always_comb begin
      greater = 1'b0;
      if (SIGNED != 0)
         greater = $signed(in_data) > $signed(max_val);
      else
         greater = in_data > max_val;
   end

   // busy/done are kept as their own flops so they switch on the same edge
   // as the state and the final comparison result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         first    <= 1'b0;
         max_val  <= '0;
         max_addr <= '0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
      end else if (clear) begin
         state   <= ACC;
         first   <= 1'b1;
         count   <= '0;
         busy    <= 1'b1;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  if (count != CNT_MAX)
                     count <= count + CNT_ONE;
                  if (first || greater) begin
                     max_val  <= in_data;
                     max_addr <= in_addr;
                  end
                  first <= 1'b0;
                  if (in_last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (in_valid)
                  overrun <= 1'b1;
            end
            IDLE: ;
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_max_select.sv
// Directed bench for max_select: an unsigned and a signed instance share the
// stimulus and are checked each cycle against a search-level model.
module tb_max_select;

   logic       clk;
   logic       reset;
   logic       clear;
   logic       in_valid;
   logic [7:0] in_data;
   logic [7:0] in_addr;
   logic       in_last;

   logic [7:0] u_val, s_val;
   logic [7:0] u_addr, s_addr;
   logic [8:0] u_cnt, s_cnt;
   logic       u_busy, s_busy, u_done, s_done, u_ovr, s_ovr;

   int n_checks = 0;
   int n_err    = 0;

   max_select #(.DATA_W(8), .ADDR_W(8), .SIGNED(0)) u_uns (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_data(in_data), .in_addr(in_addr), .in_last(in_last),
      .max_val(u_val), .max_addr(u_addr), .count(u_cnt),
      .busy(u_busy), .done(u_done), .overrun(u_ovr)
   );

   max_select #(.DATA_W(8), .ADDR_W(8), .SIGNED(1)) u_sgn (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_data(in_data), .in_addr(in_addr), .in_last(in_last),
      .max_val(s_val), .max_addr(s_addr), .count(s_cnt),
      .busy(s_busy), .done(s_done), .overrun(s_ovr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a search is the list of accepted samples; results follow from it.
   typedef struct packed { logic [7:0] d; logic [7:0] a; } sample_t;
   sample_t   q[$];
   int        m_phase = 0;  // 0 idle, 1 searching, 2 finished
   bit        m_ovr   = 0;
   sample_t   hold_u  = '0;
   sample_t   hold_s  = '0;

   function automatic sample_t best(input bit sgn, input sample_t hold);
      sample_t b;
      if (q.size() == 0) return hold;
      b = q[0];
      for (int unsigned i = 1; i < q.size(); i++) begin
         if (sgn ? ($signed(q[i].d) > $signed(b.d)) : (q[i].d > b.d))
            b = q[i];
      end
      return b;
   endfunction

   function automatic logic [8:0] exp_count();
      return (q.size() > 256) ? 9'd256 : 9'(q.size());
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_phase = 0;
         m_ovr   = 0;
         hold_u  = '0;
         hold_s  = '0;
      end else if (clear) begin
         hold_u  = best(1'b0, hold_u);
         hold_s  = best(1'b1, hold_s);
         q.delete();
         m_phase = 1;
         m_ovr   = 0;
      end else if (m_phase == 1 && in_valid) begin
         q.push_back({in_data, in_addr});
         if (in_last) m_phase = 2;
      end else if (m_phase == 2 && in_valid) begin
         m_ovr = 1;
      end
   end

   always @(negedge clk) begin
      sample_t eu, es;
      eu = best(1'b0, hold_u);
      es = best(1'b1, hold_s);
      check("u.max_val",  u_val,  eu.d);
      check("u.max_addr", u_addr, eu.a);
      check("u.count",    u_cnt,  exp_count());
      check("u.busy",     u_busy, m_phase == 1);
      check("u.done",     u_done, m_phase == 2);
      check("u.overrun",  u_ovr,  m_ovr);
      check("s.max_val",  s_val,  es.d);
      check("s.max_addr", s_addr, es.a);
      check("s.count",    s_cnt,  exp_count());
      check("s.busy",     s_busy, m_phase == 1);
      check("s.done",     s_done, m_phase == 2);
      check("s.overrun",  s_ovr,  m_ovr);
   end

   // Called at a negedge; the next posedge consumes the inputs.
   task automatic drive(input logic c, input logic v, input logic l,
                        input logic [7:0] d, input logic [7:0] a);
      clear = c; in_valid = v; in_last = l; in_data = d; in_addr = a;
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_addr = '0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] ud [5];
      logic [7:0] rd [6];
      ud = '{8'd3, 8'd9, 8'd2, 8'd9, 8'd7};
      rd = '{8'd4, 8'd1, 8'd8, 8'd8, 8'd0, 8'd5};
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_data = '0; in_addr = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst.val", u_val, 0);
      check("rst.flags", {u_busy, u_done, u_ovr}, 0);

      // Sample in IDLE is ignored
      drive(0, 1, 1, 8'h55, 8'h03);
      check("idle.count", u_cnt, 0);
      check("idle.done", u_done, 0);

      // Unsigned run with a tie
      drive(1, 0, 0, 0, 0);
      check("run1.busy", u_busy, 1);
      for (int i = 0; i < 5; i++)
         drive(0, 1, i == 4, ud[i], 8'h10 + 8'(i));
      check("run1.val", u_val, 9);
      check("run1.addr", u_addr, 8'h11);
      check("run1.count", u_cnt, 5);
      check("run1.done_busy", {u_done, u_busy}, 2'b10);

      // Overrun in DONE, results held
      drive(0, 1, 0, 8'hFF, 8'h99);
      check("ovr.set", u_ovr, 1);
      check("ovr.val", u_val, 9);
      check("ovr.count", u_cnt, 5);

      // Clear together with a sample: sample dropped
      drive(1, 1, 0, 8'hFF, 8'h77);
      check("clr.ovr", u_ovr, 0);
      check("clr.count", u_cnt, 0);
      check("clr.held", u_val, 9);

      // Signed-vs-unsigned run: -16, -123, -2
      drive(0, 1, 0, 8'hF0, 8'h20);
      drive(0, 1, 0, 8'h85, 8'h21);
      drive(0, 0, 1, 8'hAA, 8'h2F);   // in_last without in_valid
      drive(0, 1, 1, 8'hFE, 8'h22);
      check("sgn.val", s_val, 8'hFE);
      check("sgn.addr", s_addr, 8'h22);
      check("uns.val", u_val, 8'hFE);
      check("uns.addr", u_addr, 8'h22);

      // Distinguishing pair
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 8'h7F, 8'h30);
      drive(0, 1, 1, 8'h80, 8'h31);
      check("pair.s_val", s_val, 8'h7F);
      check("pair.s_addr", s_addr, 8'h30);
      check("pair.u_val", u_val, 8'h80);
      check("pair.u_addr", u_addr, 8'h31);

      // Single-sample search
      drive(1, 0, 0, 0, 0);
      check("n1.busy", u_busy, 1);
      drive(0, 1, 1, 8'h00, 8'h40);
      check("n1.val", u_val, 0);
      check("n1.addr", u_addr, 8'h40);
      check("n1.count", u_cnt, 1);
      check("n1.done_busy", {u_done, u_busy}, 2'b10);

      // Reset mid-search, then a full run
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         drive(0, 1, 0, 8'hE0 + 8'(i), 8'h50 + 8'(i));
      pulse_reset();
      check("mid.val", u_val, 0);
      check("mid.count", u_cnt, 0);
      check("mid.busy", u_busy, 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++)
         drive(0, 1, i == 5, rd[i], 8'(i));
      check("rerun.val", u_val, 8);
      check("rerun.addr", u_addr, 2);
      check("rerun.count", u_cnt, 6);

      // Count saturation at 256
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 260; i++)
         drive(0, 1, 0, 8'(i % 200), 8'(i));
      check("sat.count", u_cnt, 256);
      check("sat.val", u_val, 199);
      check("sat.addr", u_addr, 199);
      drive(0, 1, 1, 8'h00, 8'h00);
      check("sat.final", u_cnt, 256);
      check("sat.done", u_done, 1);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
